unidade_controle_exp7: RTL and testbench
========================================

# unidade_controle_exp7

Moore control unit for the sequence-memory game datapath with a "show sequence" phase. Each round it first replays the stored sequence on the LEDs, one element at a time, under a display timer. It then waits for the player's plays, compares each one, and advances rounds. It drives the existing datapath counters (address E, round Rod, display timer M, timeout timer T) and the play register R, and reports the game outcome.

## Interface
- No parameters. State encoding is fixed, 4 bits; see Operation.
- clock  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high; forces state inicial.
- iniciar  in  1  start/restart request.
- jogada  in  1  play-detected pulse from the edge detector.
- igual  in  1  R equals memory[E].
- enderecoIgualRodada  in  1  E == Rod.
- fimRod  in  1  Rod at its terminal count (last round).
- fimM  in  1  display timer at its terminal count. M is a wrapping modulo counter: counting at the terminal value returns it to 0.
- fimT  in  1  timeout timer at its terminal count.
- zeraE, contaE, zeraRod, contaRod, zeraM, contaM, zeraT, contaT, zeraR, registraR  out  1 each  datapath controls.
- mostraLed  out  1  selects memory[E] onto the LEDs.
- acertou, errou, timeout, pronto  out  1 each  result flags.
- db_estado  out  4  current state code; F for an illegal code.

## Operation
States and their codes:
- 0 inicial, 1 preparacao, 2 inicia_rodada, 3 mostra_led, 4 apaga_led, 5 proximo_led, 6 reinicia_jogada.
- 7 espera_jogada, 8 registra, 9 comparacao, B proximo, D proxima_rodada.
- A fim_acertou, E fim_errou, C fim_timeout.

Transitions:
- inicial: iniciar → preparacao, else hold.
- preparacao → inicia_rodada → mostra_led (unconditional).
- mostra_led: fimM → apaga_led, else hold.
- apaga_led: fimM → (enderecoIgualRodada ? reinicia_jogada : proximo_led), else hold.
- proximo_led → mostra_led; reinicia_jogada → espera_jogada.
- espera_jogada: jogada → registra; else fimT → fim_timeout; else hold. jogada has priority over fimT in the same cycle.
- registra → comparacao.
- comparacao, evaluated in this priority order:
  - ~igual → fim_errou.
  - enderecoIgualRodada & fimRod → fim_acertou.
  - enderecoIgualRodada → proxima_rodada.
  - otherwise → proximo.
- proximo → espera_jogada; proxima_rodada → inicia_rodada.
- fim_*: iniciar → preparacao, else hold.
- Illegal codes (F) → inicial.

Moore outputs (each signal high only in the listed states):
- zeraE: inicial, preparacao, inicia_rodada, reinicia_jogada. contaE: proximo_led, proximo.
- zeraRod: inicial, preparacao. contaRod: proxima_rodada.
- zeraM: inicial, preparacao, inicia_rodada, proximo_led. contaM: mostra_led, apaga_led.
- zeraT: inicial, preparacao, reinicia_jogada, proximo. contaT: espera_jogada.
- zeraR: inicial, preparacao. registraR: registra.
- mostraLed: mostra_led.
- pronto: any fim_* state. acertou: fim_acertou. errou: fim_errou. timeout: fim_timeout.

## Timing
- Reset: a rising edge with reset=1 loads inicial, overriding all inputs including iniciar. The state is undefined until that first edge.
- Outputs in inicial:
  - zeraE, zeraRod, zeraM, zeraT, zeraR = 1.
  - All other outputs = 0; db_estado = 0.
- Reset asserted in any state, including mid-display or a fim_* state, returns to inicial on the next edge.
- Outputs are pure functions of the state and change only after a clock edge. Inputs never reach outputs in the same cycle.
- Start latency: iniciar sampled at edge k gives preparacao after k, inicia_rodada after k+1, and mostra_led (mostraLed=1) after k+2.
- Display timing, with an M-cycle modulo timer:
  - mostra_led lasts M cycles; apaga_led lasts M cycles.
  - proximo_led lasts 1 cycle.
  - Round r (r+1 elements) takes (r+1)·2M + r cycles of display, then 1 cycle in reinicia_jogada.
- Play latency: jogada at edge n gives registra after n, comparacao after n+1, and the decision state after n+2.
- Timeout: T is cleared on entry to each play. fim_timeout is entered the edge after fimT is seen in espera_jogada.

## Configuration
- Macro TIMEOUT_EN.
- Defined: behaviour as above.
- Undefined:
  - contaT is held 0 and fimT is ignored, so espera_jogada waits indefinitely.
  - fim_timeout is unreachable; timeout stays 0.
  - zeraT is unchanged. Code C is treated as illegal (→ inicial, db_estado=F).

## Test plan
Bench models 4-bit E/Rod counters, M terminal at 3 (4-cycle display), T terminal at 9, and memory {1,2,4,8}.
- Reset with iniciar=1 → state inicial, db_estado=0, all zera*=1, others 0. One idle cycle later, iniciar=1 → db_estado goes 1, 2, 3 on successive edges, mostraLed=1 for 4 cycles.
- Round 0, correct play → display sequence 3(×4), 4(×4), 6, 7; jogada with igual=1 → 8, 9, D, 2; Rod=1.
- Round 1, second play wrong (igual=0) → fim_errou: db_estado=E, errou=1, pronto=1, stays there until iniciar.
- All 4 rounds correct with fimRod=1 at the last comparacao → db_estado=A, acertou=1, pronto=1. iniciar → 1.
- No jogada for 10 cycles in espera_jogada → db_estado=C, timeout=1. Same test without TIMEOUT_EN → stays in 7, contaT=0. jogada and fimT in the same cycle → registra (8).
- Reset asserted during mostra_led → inicial on the next edge, mostraLed=0.

Source files
------------

// File: rtl/unidade_controle_exp7.sv
// unidade_controle_exp7 -- Moore control unit for the sequence-memory game.
// Each round replays the stored sequence on the LEDs (mostra_led/apaga_led
// paced by the display timer M), then collects and checks the player's plays.
// Optional feature macro: TIMEOUT_EN (enables the play timeout path through
// state fim_timeout, code C). Without it espera_jogada waits indefinitely and
// code C is treated as illegal.
//
// Input protocol: jogada is a one-cycle pulse from the edge detector; the play
// value must already be on the R input when jogada is seen, and stay there
// until registra has loaded it. igual, enderecoIgualRodada, fimRod, fimM and
// fimT are level signals from the datapath describing its current contents.
module unidade_controle_exp7 (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       enderecoIgualRodada,
  input  logic       fimRod,
  input  logic       fimM,
  input  logic       fimT,
  output logic       zeraE,
  output logic       contaE,
  output logic       zeraRod,
  output logic       contaRod,
  output logic       zeraM,
  output logic       contaM,
  output logic       zeraT,
  output logic       contaT,
  output logic       zeraR,
  output logic       registraR,
  output logic       mostraLed,
  output logic       acertou,
  output logic       errou,
  output logic       timeout,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    stInicial        = 4'h0,
    stPreparacao     = 4'h1,
    stIniciaRodada   = 4'h2,
    stMostraLed      = 4'h3,
    stApagaLed       = 4'h4,
    stProximoLed     = 4'h5,
    stReiniciaJogada = 4'h6,
    stEsperaJogada   = 4'h7,
    stRegistra       = 4'h8,
    stComparacao     = 4'h9,
    stFimAcertou     = 4'hA,
    stProximo        = 4'hB,
    stFimTimeout     = 4'hC,
    stProximaRodada  = 4'hD,
    stFimErrou       = 4'hE
  } estado_t;

  typedef struct packed {
    logic zeraE;
    logic contaE;
    logic zeraRod;
    logic contaRod;
    logic zeraM;
    logic contaM;
    logic zeraT;
    logic contaT;
    logic zeraR;
    logic registraR;
    logic mostraLed;
    logic acertou;
    logic errou;
    logic timeout;
    logic pronto;
  } saidas_t;

  estado_t estado;
  saidas_t saidas;

`ifndef TIMEOUT_EN
  // fimT has no effect when the timeout path is compiled out.
  logic unusedFimT;
  assign unusedFimT = fimT;
`endif

  // Transition rules; any code outside the legal set falls back to inicial.
  function automatic estado_t proximoEstado(input estado_t atual);
    estado_t prox;
    prox = stInicial;
    case (atual)
      stInicial:        prox = iniciar ? stPreparacao : stInicial;
      stPreparacao:     prox = stIniciaRodada;
      stIniciaRodada:   prox = stMostraLed;
      stMostraLed:      prox = fimM ? stApagaLed : stMostraLed;
      stApagaLed: begin
        if (!fimM)                    prox = stApagaLed;
        else if (enderecoIgualRodada) prox = stReiniciaJogada;
        else                          prox = stProximoLed;
      end
      stProximoLed:     prox = stMostraLed;
      stReiniciaJogada: prox = stEsperaJogada;
      stEsperaJogada: begin
        if (jogada)    prox = stRegistra;
`ifdef TIMEOUT_EN
        else if (fimT) prox = stFimTimeout;
`endif
        else           prox = stEsperaJogada;
      end
      stRegistra:       prox = stComparacao;
      stComparacao: begin
        if (!igual)                             prox = stFimErrou;
        else if (enderecoIgualRodada && fimRod) prox = stFimAcertou;
        else if (enderecoIgualRodada)           prox = stProximaRodada;
        else                                    prox = stProximo;
      end
      stProximo:        prox = stEsperaJogada;
      stProximaRodada:  prox = stIniciaRodada;
      stFimAcertou:     prox = iniciar ? stPreparacao : stFimAcertou;
      stFimErrou:       prox = iniciar ? stPreparacao : stFimErrou;
`ifdef TIMEOUT_EN
      stFimTimeout:     prox = iniciar ? stPreparacao : stFimTimeout;
`endif
      default:          prox = stInicial;
    endcase
    return prox;
  endfunction

  // Moore output decode for a given state.
  function automatic saidas_t decodifica(input estado_t e);
    saidas_t s;
    s = '0;
    s.zeraE     = e inside {stInicial, stPreparacao, stIniciaRodada, stReiniciaJogada};
    s.contaE    = e inside {stProximoLed, stProximo};
    s.zeraRod   = e inside {stInicial, stPreparacao};
    s.contaRod  = (e == stProximaRodada);
    s.zeraM     = e inside {stInicial, stPreparacao, stIniciaRodada, stProximoLed};
    s.contaM    = e inside {stMostraLed, stApagaLed};
    s.zeraT     = e inside {stInicial, stPreparacao, stReiniciaJogada, stProximo};
    s.zeraR     = e inside {stInicial, stPreparacao};
    s.registraR = (e == stRegistra);
    s.mostraLed = (e == stMostraLed);
    s.acertou   = (e == stFimAcertou);
    s.errou     = (e == stFimErrou);
`ifdef TIMEOUT_EN
    s.contaT    = (e == stEsperaJogada);
    s.timeout   = (e == stFimTimeout);
    s.pronto    = e inside {stFimAcertou, stFimErrou, stFimTimeout};
`else
    s.contaT    = 1'b0;
    s.timeout   = 1'b0;
    s.pronto    = e inside {stFimAcertou, stFimErrou};
`endif
    return s;
  endfunction

  // Codes the debug port reports as-is; anything else reads back as F.
  function automatic logic codigoValido(input logic [3:0] c);
`ifdef TIMEOUT_EN
    return (c != 4'hF);
`else
    return !(c inside {4'hC, 4'hF});
`endif
  endfunction

  // State register with outputs registered from the upcoming state, so every
  // output equals the decode of the state it is presented with.
  always_ff @(posedge clock) begin
    if (reset) begin
      estado <= stInicial;
      saidas <= decodifica(stInicial);
    end else begin
      estado <= proximoEstado(estado);
      saidas <= decodifica(proximoEstado(estado));
    end
  end

  assign zeraE     = saidas.zeraE;
  assign contaE    = saidas.contaE;
  assign zeraRod   = saidas.zeraRod;
  assign contaRod  = saidas.contaRod;
  assign zeraM     = saidas.zeraM;
  assign contaM    = saidas.contaM;
  assign zeraT     = saidas.zeraT;
  assign contaT    = saidas.contaT;
  assign zeraR     = saidas.zeraR;
  assign registraR = saidas.registraR;
  assign mostraLed = saidas.mostraLed;
  assign acertou   = saidas.acertou;
  assign errou     = saidas.errou;
  assign timeout   = saidas.timeout;
  assign pronto    = saidas.pronto;
  assign db_estado = codigoValido(estado) ? estado : 4'hF;

endmodule

// File: tb/tb_unidade_controle_exp7.sv
// tb_unidade_controle_exp7 -- bench for unidade_controle_exp7 with a small
// datapath model around it (E/Rod counters, display timer M terminal at 3,
// timeout timer T terminal at 9, play register R, memory {1,2,4,8}).
// Expected per-cycle state codes come from the game rules; outputs are
// derived from the state code.
module tb_unidade_controle_exp7;

  logic       clock = 1'b0;
  logic       reset, iniciar, jogada;
  logic       igual, enderecoIgualRodada, fimRod, fimM, fimT;
  logic       zeraE, contaE, zeraRod, contaRod, zeraM, contaM;
  logic       zeraT, contaT, zeraR, registraR, mostraLed;
  logic       acertou, errou, timeout, pronto;
  logic [3:0] db_estado;

  unidade_controle_exp7 dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .enderecoIgualRodada(enderecoIgualRodada), .fimRod(fimRod),
    .fimM(fimM), .fimT(fimT),
    .zeraE(zeraE), .contaE(contaE), .zeraRod(zeraRod), .contaRod(contaRod),
    .zeraM(zeraM), .contaM(contaM), .zeraT(zeraT), .contaT(contaT),
    .zeraR(zeraR), .registraR(registraR), .mostraLed(mostraLed),
    .acertou(acertou), .errou(errou), .timeout(timeout), .pronto(pronto),
    .db_estado(db_estado)
  );

  // clock / reset
  always #5 clock = ~clock;

  // datapath model
  logic [3:0] eReg = 4'd0, rodReg = 4'd0, mReg = 4'd0, tReg = 4'd0, rReg = 4'd0;
  logic [3:0] valorJogada = 4'd0;

  function automatic logic [3:0] memoria(input logic [3:0] a);
    logic [3:0] tabela [4];
    tabela = '{4'd1, 4'd2, 4'd4, 4'd8};
    return (a < 4'd4) ? tabela[a[1:0]] : 4'd0;
  endfunction

  assign igual               = (rReg == memoria(eReg));
  assign enderecoIgualRodada = (eReg == rodReg);
  assign fimRod              = (rodReg == 4'd3);
  assign fimM                = (mReg == 4'd3);
  assign fimT                = (tReg == 4'd9);

  always @(posedge clock) begin
    if (zeraE) eReg <= 4'd0;
    else if (contaE) eReg <= eReg + 4'd1;
    if (zeraRod) rodReg <= 4'd0;
    else if (contaRod) rodReg <= rodReg + 4'd1;
    if (zeraM) mReg <= 4'd0;
    else if (contaM) mReg <= (mReg == 4'd3) ? 4'd0 : mReg + 4'd1;
    if (zeraT) tReg <= 4'd0;
    else if (contaT) tReg <= (tReg == 4'd9) ? 4'd0 : tReg + 4'd1;
    if (zeraR) rReg <= 4'd0;
    else if (registraR) rReg <= valorJogada;
  end

  // scoreboard
  logic [18:0] exp_q[$];
  int total = 0;
  int bad = 0;

  // Expected {state code, output flags} for a state, read off the output table.
  function automatic logic [18:0] esperado(input logic [3:0] c);
    logic [14:0] f;
    f = '0;
    f[14] = c inside {4'h0, 4'h1, 4'h2, 4'h6};        // zeraE
    f[13] = c inside {4'h5, 4'hB};                    // contaE
    f[12] = c inside {4'h0, 4'h1};                    // zeraRod
    f[11] = (c == 4'hD);                              // contaRod
    f[10] = c inside {4'h0, 4'h1, 4'h2, 4'h5};        // zeraM
    f[9]  = c inside {4'h3, 4'h4};                    // contaM
    f[8]  = c inside {4'h0, 4'h1, 4'h6, 4'hB};        // zeraT
`ifdef TIMEOUT_EN
    f[7]  = (c == 4'h7);                              // contaT
    f[1]  = (c == 4'hC);                              // timeout
`endif
    f[6]  = c inside {4'h0, 4'h1};                    // zeraR
    f[5]  = (c == 4'h8);                              // registraR
    f[4]  = (c == 4'h3);                              // mostraLed
    f[3]  = (c == 4'hA);                              // acertou
    f[2]  = (c == 4'hE);                              // errou
    f[0]  = c inside {4'hA, 4'hE, 4'hC};              // pronto
    return {c, f};
  endfunction

  // monitor: one observation per clock, #1 after the edge
  initial begin
    logic [18:0] atual, exp;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        exp   = exp_q.pop_front();
        atual = {db_estado, zeraE, contaE, zeraRod, contaRod, zeraM, contaM,
                 zeraT, contaT, zeraR, registraR, mostraLed, acertou, errou,
                 timeout, pronto};
        total++;
        if (atual !== exp) begin
          bad++;
          $display("FAIL estado_saidas t=%0t: got estado=%h outs=%b, expected estado=%h outs=%b",
                   $time, atual[18:15], atual[14:0], exp[18:15], exp[14:0]);
        end
      end
    end
  end

  // driver tasks: inputs are set by the caller, then one clock elapses
  task automatic cycle(input logic [3:0] c);
    exp_q.push_back(esperado(c));
    @(negedge clock);
  endtask

  // Display of round r: r+1 elements, each 4 cycles lit and 4 dark, with one
  // proximo_led between elements, then reinicia_jogada and espera_jogada.
  task automatic showRound(input int r);
    for (int i = 0; i <= r; i++) begin
      repeat (4) cycle(4'h3);
      repeat (4) cycle(4'h4);
      if (i < r) cycle(4'h5);
    end
    cycle(4'h6);
    cycle(4'h7);
  endtask

  // One play of element i in round r, after a random idle time.
  task automatic play(input int r, input int i, input bit correto, output bit fim);
    int d;
    logic [3:0] erro;
    fim = 1'b0;
    d = $urandom_range(0, 6);
    repeat (d) cycle(4'h7);
    erro = 4'($urandom_range(1, 15));
    valorJogada = correto ? memoria(4'(i)) : (memoria(4'(i)) ^ erro);
    jogada = 1'b1;
    cycle(4'h8);
    jogada = 1'b0;
    cycle(4'h9);
    if (!correto) begin
      cycle(4'hE);
      fim = 1'b1;
    end else if (i == r && r == 3) begin
      cycle(4'hA);
      fim = 1'b1;
    end else if (i == r) begin
      cycle(4'hD);
      cycle(4'h2);
    end else begin
      cycle(4'hB);
      cycle(4'h7);
    end
  endtask

  // A game from iniciar; the play (wr, wi) is wrong, wr < 0 means none.
  task automatic runGame(input int wr, input int wi);
    bit fim;
    iniciar = 1'b1;
    cycle(4'h1);
    iniciar = 1'b0;
    cycle(4'h2);
    for (int r = 0; r < 4; r++) begin
      showRound(r);
      for (int i = 0; i <= r; i++) begin
        play(r, i, !(r == wr && i == wi), fim);
        if (fim) return;
      end
    end
  endtask

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got no end of stimulus, expected finish before time limit");
    $fatal(1);
  end

  // stimulus
  initial begin
    reset = 1'b1; iniciar = 1'b1; jogada = 1'b0;
    cycle(4'h0);                       // reset overrides iniciar
    reset = 1'b0; iniciar = 1'b0;
    cycle(4'h0);                       // idle

    runGame(1, $urandom_range(0, 1));  // wrong play in round 1
    iniciar = 1'b0;
    repeat (3) cycle(4'hE);

    runGame(-1, 0);                    // all four rounds correct
    iniciar = 1'b0;
    repeat (2) cycle(4'hA);

    iniciar = 1'b1; cycle(4'h1);       // reset during mostra_led
    iniciar = 1'b0; cycle(4'h2);
    repeat (2) cycle(4'h3);
    reset = 1'b1; iniciar = 1'($urandom_range(0, 1));
    cycle(4'h0);
    reset = 1'b0; iniciar = 1'b0;
    cycle(4'h0);

    iniciar = 1'b1; cycle(4'h1);       // jogada coinciding with fimT
    iniciar = 1'b0; cycle(4'h2);
    showRound(0);
    repeat (9) cycle(4'h7);
    valorJogada = memoria(4'd0);
    jogada = 1'b1; cycle(4'h8);
    jogada = 1'b0; cycle(4'h9);
    cycle(4'hD);
    cycle(4'h2);
    showRound(1);                      // no play at all in round 1
    repeat (9) cycle(4'h7);
`ifdef TIMEOUT_EN
    repeat (3) cycle(4'hC);
    iniciar = 1'b1; cycle(4'h1);
    iniciar = 1'b0; cycle(4'h2);
`else
    repeat (12) cycle(4'h7);
`endif
    reset = 1'b1; cycle(4'h0);
    reset = 1'b0; cycle(4'h0);

    @(negedge clock);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending, expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
